dma_addr_controller: RTL and testbench
======================================

DMA_ADDR_CONTROLLER -- requirements
Module: dma_addr_controller

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning the number of DMA read channels (1..8); channel 0 has highest priority.
REQ-002 SHALL have parameter ADDR_W, default 21, meaning the RAM word-address width.
REQ-003 SHALL have parameter MIN_AW, default 16, meaning the address width of the smallest RAM size code.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk input 1, system clock; reset input 1, synchronous active-high reset.
REQ-005 SHALL have ports: cycleReady input 1, end-of-bus-cycle strobe; videoBusControl input 1, current cycle is a DMA/video slot; cpuBusControl input 1, current cycle is a CPU slot.
REQ-006 SHALL have ports: ramSizeSel input 3, RAM size code; cpuAddr input ADDR_W, CPU word address; selectRAM input 1, decoded CPU RAM select; _cpuRW, _cpuUDS, _cpuLDS input 1 each, CPU strobes (active low).
REQ-007 SHALL have per-channel ports: chBase input NCH*ADDR_W, reload addresses; chReload input NCH, load-base pulses; chReq input NCH, fetch-request pulses.
REQ-008 SHALL have outputs: chLoad output NCH, one-hot data-valid strobe; chOverrun output NCH, sticky missed-request flags; ramAddr output ADDR_W; _ramOE, _ramWE, _memoryUDS, _memoryLDS output 1 each.

Function
REQ-009 SHALL set pending[i] on the clk edge after chReq[i]=1; a chReq[i] while pending[i] is already set SHALL also set chOverrun[i], which stays set until reset.
REQ-010 SHALL load addr[i] from chBase[i] on chReload[i]; reload wins over a same-edge increment.
REQ-011 SHALL, on each cycleReady, register grantValid = OR of (pending & ~completing) and grantCh = lowest index among those bits; the grant holds until the next cycleReady.
REQ-012 SHALL complete channel i on cycleReady when grantValid && grantCh==i && videoBusControl: clear pending[i] and increment addr[i] modulo 2^ADDR_W.
REQ-013 SHALL keep pending[i] set when chReq[i] and completion of i coincide; this case SHALL NOT set overrun.
REQ-014 SHALL carry a grant over, with no completion and no increment, when grantValid is set but videoBusControl=0 at cycleReady.
REQ-015 SHALL drive chLoad[i] = grantValid && grantCh==i && videoBusControl, combinationally.
REQ-016 SHALL define dmaAccess = OR of chLoad, and cpuAccess = selectRAM && (cpuBusControl || (videoBusControl && !grantValid)).
REQ-017 SHALL drive _ramOE = ~((cpuAccess && _cpuRW) || dmaAccess) and _ramWE = ~(cpuAccess && !_cpuRW).
REQ-018 SHALL force _memoryUDS and _memoryLDS to 0 during dmaAccess, and otherwise pass through the CPU strobes.
REQ-019 SHALL select ramAddr as addr[grantCh] during dmaAccess, and otherwise cpuAddr.
REQ-020 SHALL force to 0 every ramAddr bit at or above MIN_AW+ramSizeSel, with that bound clamped to ADDR_W.

Reset
REQ-021 SHALL clear pending, addr, grantValid, grantCh and chOverrun to 0 while reset=1; chLoad=0, _ramWE=1.
REQ-022 SHALL abort an in-flight grant on reset mid-cycle without incrementing its address.

Structure
REQ-023 SHALL place the RAM size codes, MIN_AW default and channel-index constants (CH_VIDEO=0, CH_AUDIO=1) in shared package mem_pkg.
REQ-024 SHALL implement per-channel pending/overrun/address state in one sub-module, dma_channel, instantiated NCH times by generate.
REQ-025 SHALL keep the priority encoder and muxes in the top level; the RTL SHALL be 120-400 lines total.

Verification
REQ-026 SHALL check: reload ch0 base 0x1FD080, three chReq each serviced in a video slot -> chLoad[0] three times, ramAddr 0x1FD080, 0x1FD081, 0x1FD082.
REQ-027 SHALL check: chReq on ch0 and ch1 on the same clk -> ch0 served in the first video slot and ch1 in the next; chOverrun stays 00.
REQ-028 SHALL check: ch1 addr 0x1FFFFF completes -> addr wraps to 0x000000; ramSizeSel=1 with cpuAddr 0x1ABCDE -> ramAddr 0x00BCDE.
REQ-029 SHALL check: second chReq[0] before service -> chOverrun[0]=1 and exactly one fetch occurs; chReq coincident with completion -> a second fetch occurs with no overrun.
REQ-030 SHALL check: CPU write with selectRAM in a video slot with no grant -> _ramWE=0 and ramAddr=cpuAddr; the same slot with a grant -> _ramWE=1 and _memoryUDS=_memoryLDS=0.
REQ-031 SHALL check: reset asserted while grantValid=1 -> all outputs return to reset values next clk and addr is not incremented.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-map constants: RAM size codes, base address width and DMA channel indices.
package mem_pkg;

  localparam int unsigned MIN_AW_DEF = 16;

  // RAM size codes; each code step doubles the addressable word range
  localparam logic [2:0] RAM_64K  = 3'd0;
  localparam logic [2:0] RAM_128K = 3'd1;
  localparam logic [2:0] RAM_256K = 3'd2;
  localparam logic [2:0] RAM_512K = 3'd3;
  localparam logic [2:0] RAM_1M   = 3'd4;
  localparam logic [2:0] RAM_2M   = 3'd5;

  localparam int unsigned CH_VIDEO = 0;
  localparam int unsigned CH_AUDIO = 1;

  // Number of live RAM address bits for a size code, clamped to the bus width
  function automatic int unsigned addr_bound(input int unsigned min_aw,
                                             input logic [2:0]  code,
                                             input int unsigned addr_w);
    int unsigned b;
    b = min_aw + 32'(code);
    return (b > addr_w) ? addr_w : b;
  endfunction

endpackage

// File: rtl/dma_channel.sv
// One DMA read channel: request pending flag, sticky overrun flag and word-address pointer.
module dma_channel #(
  parameter int unsigned ADDR_W = 21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              reload_i,
  input  logic              req_i,
  input  logic              complete_i,
  output logic              pending_o,
  output logic              overrun_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // A request landing on the completing edge re-arms the channel rather than overrunning
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q | (req_i && pending_q && !complete_i);
    addr_d    = addr_q;
    if (req_i) begin
      pending_d = 1'b1;
    end else if (complete_i) begin
      pending_d = 1'b0;
    end
    if (reload_i) begin
      addr_d = base_i;
    end else if (complete_i) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      addr_q    <= addr_d;
    end
  end

  assign pending_o = pending_q;
  assign overrun_o = overrun_q;
  assign addr_o    = addr_q;

endmodule

// File: rtl/dma_addr_controller.sv
// Shares one RAM port between CPU slots and prioritised DMA read channels;
// owns channel arbitration, RAM address muxing/masking and strobe generation.
module dma_addr_controller
  import mem_pkg::*;
#(
  parameter int unsigned NCH    = 2,
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned MIN_AW = MIN_AW_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cycleReady,
  input  logic                  videoBusControl,
  input  logic                  cpuBusControl,
  input  logic [2:0]            ramSizeSel,
  input  logic [ADDR_W-1:0]     cpuAddr,
  input  logic                  selectRAM,
  input  logic                  _cpuRW,
  input  logic                  _cpuUDS,
  input  logic                  _cpuLDS,
  input  logic [NCH*ADDR_W-1:0] chBase,
  input  logic [NCH-1:0]        chReload,
  input  logic [NCH-1:0]        chReq,
  output logic [NCH-1:0]        chLoad,
  output logic [NCH-1:0]        chOverrun,
  output logic [ADDR_W-1:0]     ramAddr,
  output logic                  _ramOE,
  output logic                  _ramWE,
  output logic                  _memoryUDS,
  output logic                  _memoryLDS
);

  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]    pending;
  logic [NCH-1:0]    completing;
  logic [NCH-1:0]    serviceable;
  logic [ADDR_W-1:0] ch_addr [NCH];

  logic              grant_valid_q, grant_valid_d;
  logic [CH_W-1:0]   grant_ch_q, grant_ch_d;

  logic              dma_access;
  logic              cpu_access;
  logic [ADDR_W-1:0] dma_addr;
  logic [ADDR_W-1:0] raw_addr;
  int unsigned       live_bits;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    dma_channel #(.ADDR_W(ADDR_W)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .base_i     (chBase[g*ADDR_W +: ADDR_W]),
      .reload_i   (chReload[g]),
      .req_i      (chReq[g]),
      .complete_i (completing[g]),
      .pending_o  (pending[g]),
      .overrun_o  (chOverrun[g]),
      .addr_o     (ch_addr[g])
    );
  end

  // Data-valid strobe for the granted channel while the slot belongs to DMA
  always_comb begin
    chLoad     = '0;
    completing = '0;
    for (int i = 0; i < NCH; i++) begin
      chLoad[i]     = !reset && grant_valid_q && (grant_ch_q == CH_W'(i)) && videoBusControl;
      completing[i] = cycleReady && chLoad[i];
    end
  end

  // Fixed-priority arbitration, lowest channel index wins
  always_comb begin
    serviceable   = pending & ~completing;
    grant_valid_d = grant_valid_q;
    grant_ch_d    = grant_ch_q;
    if (cycleReady) begin
      grant_valid_d = |serviceable;
      grant_ch_d    = '0;
      for (int i = NCH - 1; i >= int'(CH_VIDEO); i--) begin
        if (serviceable[i]) begin
          grant_ch_d = CH_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_valid_q <= 1'b0;
      grant_ch_q    <= '0;
    end else begin
      grant_valid_q <= grant_valid_d;
      grant_ch_q    <= grant_ch_d;
    end
  end

  assign dma_access = |chLoad;
  assign cpu_access = !reset && selectRAM &&
                      (cpuBusControl || (videoBusControl && !grant_valid_q));

  always_comb begin
    dma_addr = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_ch_q == CH_W'(i)) begin
        dma_addr = ch_addr[i];
      end
    end
  end

  assign raw_addr  = dma_access ? dma_addr : cpuAddr;
  assign live_bits = addr_bound(MIN_AW, ramSizeSel, ADDR_W);

  // Bits beyond the fitted RAM size are forced low
  always_comb begin
    ramAddr = '0;
    for (int unsigned b = 0; b < ADDR_W; b++) begin
      ramAddr[b] = (b < live_bits) ? raw_addr[b] : 1'b0;
    end
  end

  assign _ramOE     = ~((cpu_access && _cpuRW) || dma_access);
  assign _ramWE     = ~(cpu_access && !_cpuRW);
  assign _memoryUDS = dma_access ? 1'b0 : _cpuUDS;
  assign _memoryLDS = dma_access ? 1'b0 : _cpuLDS;

endmodule

// File: tb/tb_dma_addr_controller.sv
// Directed bench for dma_addr_controller: arbitration, address stepping/wrap,
// overrun, CPU/DMA strobe muxing, size masking and reset abort.
module tb_dma_addr_controller;
  import mem_pkg::*;

  localparam int unsigned NCH = 2;
  localparam int unsigned AW  = 21;

  logic              clk = 1'b0;
  logic              reset;
  logic              cycleReady, videoBusControl, cpuBusControl;
  logic [2:0]        ramSizeSel;
  logic [AW-1:0]     cpuAddr;
  logic              selectRAM, _cpuRW, _cpuUDS, _cpuLDS;
  logic [NCH*AW-1:0] chBase;
  logic [NCH-1:0]    chReload, chReq;
  logic [NCH-1:0]    chLoad, chOverrun;
  logic [AW-1:0]     ramAddr;
  logic              _ramOE, _ramWE, _memoryUDS, _memoryLDS;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dma_addr_controller #(.NCH(NCH), .ADDR_W(AW), .MIN_AW(MIN_AW_DEF)) dut (
    .clk             (clk),
    .reset           (reset),
    .cycleReady      (cycleReady),
    .videoBusControl (videoBusControl),
    .cpuBusControl   (cpuBusControl),
    .ramSizeSel      (ramSizeSel),
    .cpuAddr         (cpuAddr),
    .selectRAM       (selectRAM),
    ._cpuRW          (_cpuRW),
    ._cpuUDS         (_cpuUDS),
    ._cpuLDS         (_cpuLDS),
    .chBase          (chBase),
    .chReload        (chReload),
    .chReq           (chReq),
    .chLoad          (chLoad),
    .chOverrun       (chOverrun),
    .ramAddr         (ramAddr),
    ._ramOE          (_ramOE),
    ._ramWE          (_ramWE),
    ._memoryUDS      (_memoryUDS),
    ._memoryLDS      (_memoryLDS)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_req(input logic [NCH-1:0] m);
    chReq = m;
    tick();
    chReq = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; cycleReady = 1'b0; videoBusControl = 1'b0; cpuBusControl = 1'b0;
    ramSizeSel = RAM_2M; cpuAddr = '0; selectRAM = 1'b0;
    _cpuRW = 1'b1; _cpuUDS = 1'b1; _cpuLDS = 1'b1;
    chBase = '0; chReload = '0; chReq = '0;
    tick(); tick();
    chk("rst_chLoad",  32'(chLoad),    32'h0);
    chk("rst_overrun", 32'(chOverrun), 32'h0);
    chk("rst_ramWE",   32'(_ramWE),    32'h1);
    chk("rst_ramOE",   32'(_ramOE),    32'h1);
    reset = 1'b0;
    tick();

    // Reload both channels, then three serviced fetches on channel 0
    chBase[CH_VIDEO*AW +: AW] = 21'h1FD080;
    chBase[CH_AUDIO*AW +: AW] = 21'h1FFFFF;
    chReload = 2'b11;
    tick();
    chReload = '0;
    cycleReady = 1'b1; videoBusControl = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pulse_req(2'b01);
      tick();
      chk("seq_chLoad", 32'(chLoad), 32'h1);
      chk("seq_addr",   32'(ramAddr), 32'h1FD080 + 32'(k));
      chk("seq_uds",    32'(_memoryUDS), 32'h0);
      tick();
      chk("seq_done",   32'(chLoad), 32'h0);
    end

    // Simultaneous requests: channel 0 first, channel 1 next, wrap of channel 1
    pulse_req(2'b11);
    tick();
    chk("pri_ch0",      32'(chLoad),  32'h1);
    chk("pri_ch0_addr", 32'(ramAddr), 32'h1FD083);
    tick();
    chk("pri_ch1",      32'(chLoad),  32'h2);
    chk("pri_ch1_addr", 32'(ramAddr), 32'h1FFFFF);
    tick();
    chk("pri_idle",     32'(chLoad),    32'h0);
    chk("pri_overrun",  32'(chOverrun), 32'h0);
    pulse_req(2'b10);
    tick();
    chk("wrap_chLoad",  32'(chLoad),  32'h2);
    chk("wrap_addr",    32'(ramAddr), 32'h000000);
    tick();

    // Size masking on a CPU read slot
    videoBusControl = 1'b0; cpuBusControl = 1'b1; selectRAM = 1'b1;
    cpuAddr = 21'h1ABCDE; ramSizeSel = RAM_128K;
    settle();
    chk("size_addr", 32'(ramAddr), 32'h00BCDE);
    chk("size_oe",   32'(_ramOE),  32'h0);
    chk("size_we",   32'(_ramWE),  32'h1);
    cpuBusControl = 1'b0; selectRAM = 1'b0; ramSizeSel = RAM_2M;
    videoBusControl = 1'b1;
    tick();

    // Request coinciding with completion re-arms without overrun
    pulse_req(2'b01);
    tick();
    chk("coin_first",      32'(chLoad),  32'h1);
    chk("coin_first_addr", 32'(ramAddr), 32'h1FD084);
    pulse_req(2'b01);
    chk("coin_gap",        32'(chLoad),  32'h0);
    tick();
    chk("coin_second",      32'(chLoad),  32'h1);
    chk("coin_second_addr", 32'(ramAddr), 32'h1FD085);
    tick();
    chk("coin_overrun", 32'(chOverrun), 32'h0);

    // Second request before service: overrun, single fetch
    videoBusControl = 1'b0;
    pulse_req(2'b01);
    pulse_req(2'b01);
    chk("ovr_flag", 32'(chOverrun), 32'h1);
    videoBusControl = 1'b1;
    settle();
    chk("ovr_fetch",      32'(chLoad),  32'h1);
    chk("ovr_fetch_addr", 32'(ramAddr), 32'h1FD086);
    tick();
    chk("ovr_after", 32'(chLoad), 32'h0);
    tick();
    chk("ovr_once",   32'(chLoad),    32'h0);
    chk("ovr_sticky", 32'(chOverrun), 32'h1);

    // CPU write in a video slot without, then with, a DMA grant
    selectRAM = 1'b1; _cpuRW = 1'b0; cpuAddr = 21'h012345;
    settle();
    chk("cpuw_we",   32'(_ramWE),  32'h0);
    chk("cpuw_addr", 32'(ramAddr), 32'h012345);
    pulse_req(2'b01);
    tick();
    chk("dmaw_we",   32'(_ramWE),     32'h1);
    chk("dmaw_uds",  32'(_memoryUDS), 32'h0);
    chk("dmaw_lds",  32'(_memoryLDS), 32'h0);
    chk("dmaw_addr", 32'(ramAddr),    32'h1FD087);

    // Reset with a live grant
    reset = 1'b1;
    tick();
    chk("abort_chLoad",  32'(chLoad),    32'h0);
    chk("abort_ramWE",   32'(_ramWE),    32'h1);
    chk("abort_overrun", 32'(chOverrun), 32'h0);
    reset = 1'b0; selectRAM = 1'b0; _cpuRW = 1'b1;
    pulse_req(2'b01);
    tick();
    chk("abort_refetch", 32'(chLoad),  32'h1);
    chk("abort_addr",    32'(ramAddr), 32'h000000);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
